camera_capture: RTL
===================

// Module: camera_capture
// PURPOSE
//  Input-side counterpart of the VGA colour output stage: receives raw sensor pixels with frame/line
//  valid strobes from the camera port and emits a frame-aligned pixel stream with X/Y coordinates.
//  Start/stop control aligns capture to frame boundaries. Output feeds the demosaic/colour path.
// PARAMETERS
//  DATA_W   12  sensor pixel width
//  X_W      12  column counter width
//  Y_W      12  row counter width
//  FRAME_W  32  frame counter width
// PORTS
//  clk          in   1        pixel clock; all logic on posedge
//  reset_n      in   1        asynchronous, active-low reset
//  start        in   1        1-cycle pulse: request capture
//  stop         in   1        1-cycle pulse: request stop at end of current frame
//  cam_data     in   DATA_W   sensor pixel data
//  cam_fval     in   1        frame valid
//  cam_lval     in   1        line valid
//  pix_data     out  DATA_W   captured pixel
//  pix_valid    out  1        pix_data/pix_x/pix_y valid this cycle
//  pix_x        out  X_W      column of pix_data, 0-based
//  pix_y        out  Y_W      row of pix_data, 0-based
//  frame_start  out  1        1-cycle pulse coincident with first pixel of each captured frame
//  frame_cnt    out  FRAME_W  number of completed captured frames
//  capturing    out  1        high in ARMED or ACTIVE
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; stop_pending 0; input registers 0.
//  - cam_data/fval/lval registered once (stage 1); fval/lval edges from stage 1 vs previous value.
//  - pix_valid = registered (fval_s1 & lval_s1 & state==ACTIVE); latency 2 clk from cam inputs.
//  - FSM: IDLE -start-> ARMED; ARMED -fval rise-> ACTIVE; ACTIVE -fval fall & stop_pending-> IDLE;
//    ACTIVE -fval fall & !stop_pending-> ARMED. Never enters ACTIVE mid-frame (fval already high
//    in ARMED is ignored until its next rising edge).
//  - stop: in ARMED -> IDLE next cycle; in ACTIVE sets stop_pending; in IDLE ignored.
//  - start in ACTIVE clears stop_pending; start in ARMED ignored.
//  - start and stop same cycle: stop wins (IDLE stays IDLE; ARMED -> IDLE; ACTIVE sets pending).
//  - pix_x: 0 on first valid pixel of each line, +1 per valid pixel, saturates at 2^X_W-1.
//  - pix_y: 0 at fval rise; +1 on lval fall within ACTIVE; saturates at 2^Y_W-1.
//  - frame_cnt: +1 on fval fall leaving ACTIVE; wraps modulo 2^FRAME_W.
//  - frame_start: asserted with pix_valid when pix_x==0 and pix_y==0.
//  - fval fall while lval high: line terminated, counters reset as for normal frame end.
//  - Reset mid-frame: immediate IDLE; next capture needs start and a fresh fval rise.
// CONFIGURATION
//  CAPTURE_SNAPSHOT_EN defined: adds input `snapshot` (1-cycle pulse). In IDLE it behaves as start
//   with stop_pending preset, capturing exactly one full frame, then IDLE. Ignored outside IDLE.
//  Not defined: no snapshot port; only start/stop control.
// STRUCTURE
//  - capture_pkg: typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} capture_state_t; default widths.
//  - Sub-module capture_edge_detect (rise/fall pulses from a registered level), used for fval and lval.
//  - FSM, counters and output registers in camera_capture itself.
// TESTING
//  1. Reset, start, 2 frames of 4 lines x 6 px -> 48 pix_valid, x 0..5, y 0..3, frame_cnt=2, frame_start x2.
//  2. start while fval already high mid-frame -> no pix_valid until next fval rise; first pixel x=0,y=0.
//  3. stop mid-frame 1 -> frame 1 completes fully, frame_cnt=1, capturing=0, frame 2 produces no pixels.
//  4. start+stop same cycle in IDLE -> stays IDLE; stop then start in same frame -> capture continues.
//  5. reset_n low mid-line -> all outputs 0 immediately; later start resumes at next frame with x=0,y=0.
//  6. CAPTURE_SNAPSHOT_EN: snapshot pulse -> exactly one frame (24 px for 4x6), frame_cnt=1, then IDLE.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared types and default widths for the camera capture block.
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } capture_state_t;

    localparam int DEF_DATA_W  = 12;
    localparam int DEF_X_W     = 12;
    localparam int DEF_Y_W     = 12;
    localparam int DEF_FRAME_W = 32;

    function automatic logic is_capturing(input capture_state_t s);
        return (s == ARMED) || (s == ACTIVE);
    endfunction

endpackage

// File: rtl/camera_capture_if.sv
// Camera-port input strobes plus the coordinate-tagged pixel stream leaving the capture block.
interface camera_capture_if
    import capture_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int X_W    = DEF_X_W,
    parameter int Y_W    = DEF_Y_W
);
    logic [DATA_W-1:0] cam_data;
    logic              cam_fval;
    logic              cam_lval;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic [X_W-1:0]    pix_x;
    logic [Y_W-1:0]    pix_y;
    logic              frame_start;

    // slave: the capture block; master: camera source plus downstream pixel consumer
    modport slave (
        input  cam_data, cam_fval, cam_lval,
        output pix_data, pix_valid, pix_x, pix_y, frame_start
    );
    modport master (
        output cam_data, cam_fval, cam_lval,
        input  pix_data, pix_valid, pix_x, pix_y, frame_start
    );
endinterface

// File: rtl/capture_edge_detect.sv
// Rise/fall pulses of an already-registered level, one cycle wide.
module capture_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic level,
    output logic rise,
    output logic fall
);
    logic level_prev_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_prev_reg <= 1'b0;
        end else begin
            level_prev_reg <= level;
        end
    end

    assign rise = level & ~level_prev_reg;
    assign fall = ~level & level_prev_reg;
endmodule

// File: rtl/camera_capture.sv
// Frame-aligned sensor capture: registers camera strobes, gates pixels by start/stop control, tags X/Y.
// Optional CAPTURE_SNAPSHOT_EN adds a `snapshot` input that captures exactly one frame from IDLE.
module camera_capture
    import capture_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int X_W     = DEF_X_W,
    parameter int Y_W     = DEF_Y_W,
    parameter int FRAME_W = DEF_FRAME_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
`ifdef CAPTURE_SNAPSHOT_EN
    input  logic               snapshot,
`endif
    camera_capture_if.slave    cam,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               capturing
);
    localparam logic [X_W-1:0] X_MAX = '1;
    localparam logic [Y_W-1:0] Y_MAX = '1;

    logic [DATA_W-1:0]  data_s1_reg;
    logic               fval_s1_reg, lval_s1_reg;
    logic [1:0]         level_s1, level_rise, level_fall;
    logic               fval_rise, fval_fall, lval_rise, lval_fall;

    capture_state_t     state_reg, state_next;
    logic               stop_pending_reg, stop_pending_next;
    logic               accept;

    logic [X_W-1:0]     x_col_reg, cur_col;
    logic [Y_W-1:0]     y_row_reg;
    logic [DATA_W-1:0]  pix_data_reg;
    logic               pix_valid_reg, frame_start_reg;
    logic [X_W-1:0]     pix_x_reg;
    logic [Y_W-1:0]     pix_y_reg;
    logic [FRAME_W-1:0] frame_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_s1_reg <= '0;
            fval_s1_reg <= 1'b0;
            lval_s1_reg <= 1'b0;
        end else begin
            data_s1_reg <= cam.cam_data;
            fval_s1_reg <= cam.cam_fval;
            lval_s1_reg <= cam.cam_lval;
        end
    end

    // bit 0 tracks frame valid, bit 1 tracks line valid
    assign level_s1 = {lval_s1_reg, fval_s1_reg};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_edge
            capture_edge_detect u_edge (
                .clk     (clk),
                .reset_n (reset_n),
                .level   (level_s1[gi]),
                .rise    (level_rise[gi]),
                .fall    (level_fall[gi])
            );
        end
    endgenerate

    assign fval_rise = level_rise[0];
    assign fval_fall = level_fall[0];
    assign lval_rise = level_rise[1];
    assign lval_fall = level_fall[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            stop_pending_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            stop_pending_reg <= stop_pending_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        stop_pending_next = stop_pending_reg;
        case (state_reg)
            IDLE: begin
                if (!stop) begin
                    if (start) begin
                        state_next        = ARMED;
                        stop_pending_next = 1'b0;
                    end
`ifdef CAPTURE_SNAPSHOT_EN
                    else if (snapshot) begin
                        state_next        = ARMED;
                        stop_pending_next = 1'b1;
                    end
`endif
                end
            end
            ARMED: begin
                if (stop) begin
                    state_next        = IDLE;
                    stop_pending_next = 1'b0;
                end else if (fval_rise) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (stop) begin
                    stop_pending_next = 1'b1;
                end else if (start) begin
                    stop_pending_next = 1'b0;
                end
                // a stop arriving on the closing cycle still ends capture with this frame
                if (fval_fall) begin
                    state_next        = stop_pending_next ? IDLE : ARMED;
                    stop_pending_next = 1'b0;
                end
            end
            default: begin
                state_next        = IDLE;
                stop_pending_next = 1'b0;
            end
        endcase
    end

    always_comb begin
        accept    = fval_s1_reg & lval_s1_reg & (state_reg == ACTIVE);
        capturing = is_capturing(state_reg);
    end

    assign cur_col = lval_rise ? '0 : x_col_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_col_reg       <= '0;
            y_row_reg       <= '0;
            pix_data_reg    <= '0;
            pix_valid_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            pix_x_reg       <= '0;
            pix_y_reg       <= '0;
            frame_cnt_reg   <= '0;
        end else begin
            pix_valid_reg   <= accept;
            frame_start_reg <= accept && (cur_col == '0) && (y_row_reg == '0);
            if (accept) begin
                pix_data_reg <= data_s1_reg;
                pix_x_reg    <= cur_col;
                pix_y_reg    <= y_row_reg;
            end

            if (fval_fall) begin
                x_col_reg <= '0;
            end else if (accept) begin
                x_col_reg <= (cur_col == X_MAX) ? cur_col : cur_col + 1'b1;
            end else if (lval_rise) begin
                x_col_reg <= '0;
            end

            if (fval_rise || fval_fall) begin
                y_row_reg <= '0;
            end else if (lval_fall && (state_reg == ACTIVE) && (y_row_reg != Y_MAX)) begin
                y_row_reg <= y_row_reg + 1'b1;
            end

            if (fval_fall && (state_reg == ACTIVE)) begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
        end
    end

    assign cam.pix_data    = pix_data_reg;
    assign cam.pix_valid   = pix_valid_reg;
    assign cam.pix_x       = pix_x_reg;
    assign cam.pix_y       = pix_y_reg;
    assign cam.frame_start = frame_start_reg;
    assign frame_cnt       = frame_cnt_reg;
endmodule
